efpga_share_ctrl: RTL and testbench

//  Shares one eFPGA accelerator between NumReq core-side eFPGA ports. Round-robin arbitration; sequences issue/strobe/wait/capture.

---
 rtl/efpga_pkg.sv | 24 ++
 rtl/efpga_rr_arbiter.sv | 31 +++
 rtl/efpga_share_ctrl.sv | 153 +++++++++++++++
 tb/tb_efpga_share_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/efpga_pkg.sv
// Shared types and widths for the eFPGA sharing controller.
package efpga_pkg;

  localparam int EfpgaDataW  = 32;
  localparam int EfpgaDelayW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef logic [1:0] efpga_op_t;

  // One requester's operation as it is handed to the fabric.
  typedef struct packed {
    logic [EfpgaDataW-1:0]  op_a;
    logic [EfpgaDataW-1:0]  op_b;
    efpga_op_t              op;
    logic [EfpgaDelayW-1:0] delay;
  } efpga_req_t;

endpackage

// File: rtl/efpga_rr_arbiter.sv
// Round-robin pick: first requesting index at or after the pointer, wrapping at NumReq.
module efpga_rr_arbiter #(
  parameter int NumReq = 2,
  parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  int cand;

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a partial assignment infers a latch.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int off = 0; off < NumReq; off++) begin
      cand = (int'(ptr_i) + off) % NumReq;
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = IdxW'(cand);
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/efpga_share_ctrl.sv
// Shares one eFPGA accelerator between NumReq core ports: round-robin grant,
// issue/strobe, fixed-delay or done-handshake wait with timeout, one-cycle response.
module efpga_share_ctrl
  import efpga_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq*EfpgaDataW-1:0]  req_op_a_i,
  input  logic [NumReq*EfpgaDataW-1:0]  req_op_b_i,
  input  logic [NumReq*2-1:0]           req_operator_i,
  input  logic [NumReq*EfpgaDelayW-1:0] req_delay_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic                          rsp_err_o,
  output logic [EfpgaDataW-1:0]         rsp_result_a_o,
  output logic [EfpgaDataW-1:0]         rsp_result_b_o,
  output logic [EfpgaDataW-1:0]         rsp_result_c_o,
  output logic [EfpgaDataW-1:0]         efpga_operand_a_o,
  output logic [EfpgaDataW-1:0]         efpga_operand_b_o,
  output logic [1:0]                    efpga_operator_o,
  output logic [EfpgaDelayW-1:0]        efpga_delay_o,
  output logic                          efpga_en_o,
  output logic                          efpga_write_strobe_o,
  input  logic [EfpgaDataW-1:0]         efpga_result_a_i,
  input  logic [EfpgaDataW-1:0]         efpga_result_b_i,
  input  logic [EfpgaDataW-1:0]         efpga_result_c_i,
  input  logic                          efpga_fpga_done_i
);

  localparam int IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntMax  = (TimeoutCycles > 15) ? TimeoutCycles : 15;
  localparam int CntW    = $clog2(CntMax + 1);
  localparam int CntIncW = CntW + 1;

  state_t            state_q, state_d;
  logic [IdxW-1:0]   rr_q, owner_q, arb_idx;
  logic [NumReq-1:0] arb_gnt;
  logic              arb_valid;
  efpga_req_t        sel_req, fab_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntIncW-1:0] cnt_inc;
  logic              capture, timeout;

  efpga_rr_arbiter #(.NumReq(NumReq), .IdxW(IdxW)) u_arb (
    .req_i  (req_i),
    .ptr_i  (rr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (arb_idx == IdxW'(i)) begin
        sel_req.op_a  = req_op_a_i[i*EfpgaDataW +: EfpgaDataW];
        sel_req.op_b  = req_op_b_i[i*EfpgaDataW +: EfpgaDataW];
        sel_req.op    = req_operator_i[i*2 +: 2];
        sel_req.delay = req_delay_i[i*EfpgaDelayW +: EfpgaDelayW];
      end
    end
  end

  // cnt_inc is the 1-based index of the current WAIT cycle.
  assign cnt_inc = {1'b0, cnt_q} + CntIncW'(1);

  always_comb begin
    state_d = state_q;
    gnt_o   = '0;
    capture = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_o   = arb_gnt;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fab_q.delay != '0) begin
          capture = (cnt_inc == CntIncW'(fab_q.delay));
        end else if (efpga_fpga_done_i) begin
          capture = 1'b1;
        end else begin
          timeout = (cnt_inc == CntIncW'(TimeoutCycles));
        end
        if (capture || timeout) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      rr_q           <= '0;
      owner_q        <= '0;
      fab_q          <= '0;
      cnt_q          <= '0;
      rsp_err_o      <= 1'b0;
      rsp_result_a_o <= '0;
      rsp_result_b_o <= '0;
      rsp_result_c_o <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            fab_q   <= sel_req;
            owner_q <= arb_idx;
            rr_q    <= (int'(arb_idx) == NumReq - 1) ? '0 : arb_idx + 1'b1;
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (capture) begin
            rsp_err_o      <= 1'b0;
            rsp_result_a_o <= efpga_result_a_i;
            rsp_result_b_o <= efpga_result_b_i;
            rsp_result_c_o <= efpga_result_c_i;
          end else if (timeout) begin
            rsp_err_o      <= 1'b1;
            rsp_result_a_o <= '0;
            rsp_result_b_o <= '0;
            rsp_result_c_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP) rsp_valid_o[owner_q] = 1'b1;
  end

  assign efpga_en_o           = (state_q == ISSUE) || (state_q == WAIT);
  assign efpga_write_strobe_o = (state_q == ISSUE);
  assign efpga_operand_a_o    = fab_q.op_a;
  assign efpga_operand_b_o    = fab_q.op_b;
  assign efpga_operator_o     = fab_q.op;
  assign efpga_delay_o        = fab_q.delay;

endmodule

// File: tb/tb_efpga_share_ctrl.sv
// Scoreboard bench for efpga_share_ctrl: random requesters, a behavioural fabric,
// and a transaction-level model predicting grants, response timing and results.
module tb_efpga_share_ctrl;
  import efpga_pkg::*;

  localparam int N = 2;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N*32-1:0] op_a_bus = '0, op_b_bus = '0;
  logic [N*2-1:0]  opr_bus = '0;
  logic [N*4-1:0]  dly_bus = '0;
  logic [N-1:0]    gnt, rsp_valid;
  logic            rsp_err, fab_en, fab_strobe, fab_done;
  logic [31:0]     rsp_a, rsp_b, rsp_c, fab_a, fab_b, res_a, res_b, res_c;
  logic [1:0]      fab_op;
  logic [3:0]      fab_dly;

  efpga_share_ctrl #(.NumReq(N), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .req_op_a_i(op_a_bus), .req_op_b_i(op_b_bus),
    .req_operator_i(opr_bus), .req_delay_i(dly_bus),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err),
    .rsp_result_a_o(rsp_a), .rsp_result_b_o(rsp_b), .rsp_result_c_o(rsp_c),
    .efpga_operand_a_o(fab_a), .efpga_operand_b_o(fab_b),
    .efpga_operator_o(fab_op), .efpga_delay_o(fab_dly),
    .efpga_en_o(fab_en), .efpga_write_strobe_o(fab_strobe),
    .efpga_result_a_i(res_a), .efpga_result_b_i(res_b), .efpga_result_c_i(res_c),
    .efpga_fpga_done_i(fab_done)
  );

  // Fabric model: result C reports the current WAIT cycle number; done fires in
  // WAIT cycle op_b[3:0], optionally during ISSUE (op_b[4]) and randomly while idle.
  logic [31:0] wcnt;
  logic        noise = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wcnt <= '0;
    else if (fab_strobe) wcnt <= '0;
    else if (fab_en)     wcnt <= wcnt + 1;
  end
  assign res_a    = fab_a + fab_b;
  assign res_b    = fab_a ^ {26'b0, fab_dly, fab_op};
  assign res_c    = (fab_en && !fab_strobe) ? wcnt + 1 : 32'hdead_beef;
  assign fab_done = (fab_en && !fab_strobe && (wcnt + 1 == {28'b0, fab_b[3:0]}))
                 || (fab_strobe && fab_b[4]) || (!fab_en && noise);

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          owner;
    int          rsp_cyc;
    logic        err;
    logic [31:0] a, b, c;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          ptr = 0;
  int          busy_until = -1;
  int          issue_cyc = -100;
  bit          mon_en = 1'b0;
  logic [N-1:0] last_gnt = '0;
  logic [31:0] txn_a[N], txn_b[N];
  logic [1:0]  txn_op[N];
  logic [3:0]  txn_d[N];
  int          remaining[N];
  logic [31:0] held_a = '0, held_b = '0, held_c = '0;
  logic        held_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t predict(input int w, input int gcyc);
    exp_t e;
    int   lat;
    e.owner = w;
    e.err   = 1'b0;
    e.a     = txn_a[w] + txn_b[w];
    e.b     = txn_a[w] ^ {26'b0, txn_d[w], txn_op[w]};
    if (txn_d[w] != 0)                                 lat = int'(txn_d[w]);
    else if (txn_b[w][3:0] >= 1 && txn_b[w][3:0] <= T) lat = int'(txn_b[w][3:0]);
    else begin
      lat   = T;
      e.err = 1'b1;
    end
    e.c = 32'(lat);
    if (e.err) begin
      e.a = '0;
      e.b = '0;
      e.c = '0;
    end
    e.rsp_cyc = gcyc + lat + 2;
    return e;
  endfunction

  // Arbitration model: grant only when idle, round-robin among sampled requests.
  always @(negedge clk) begin
    logic [N-1:0] exp_gnt;
    int           w;
    last_gnt = gnt;
    if (mon_en) begin
      exp_gnt = '0;
      w       = -1;
      if (cyc > busy_until && req != '0) begin
        for (int off = 0; off < N; off++)
          if (w < 0 && req[(ptr + off) % N]) w = (ptr + off) % N;
        exp_gnt[w] = 1'b1;
      end
      check("gnt", 64'(gnt), 64'(exp_gnt));
      if (w >= 0) begin
        exp_t e;
        e = predict(w, cyc);
        sb.push_back(e);
        busy_until = e.rsp_cyc;
        issue_cyc  = cyc + 1;
        ptr        = (w + 1) % N;
      end
      check("strobe", 64'(fab_strobe), 64'(cyc == issue_cyc));
      check("en", 64'(fab_en), 64'(cyc >= issue_cyc && cyc < busy_until));
    end
  end

  // Response monitor: pops the scoreboard whenever a response is due.
  always @(negedge clk) begin
    logic [N-1:0] exp_rv;
    exp_t         e;
    if (mon_en) begin
      exp_rv = '0;
      if (sb.size() > 0 && sb[0].rsp_cyc <= cyc) exp_rv[sb[0].owner] = 1'b1;
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv != '0) begin
        e = sb.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_a", 64'(rsp_a), 64'(e.a));
        check("rsp_b", 64'(rsp_b), 64'(e.b));
        check("rsp_c", 64'(rsp_c), 64'(e.c));
        held_err = e.err;
        held_a   = e.a;
        held_b   = e.b;
        held_c   = e.c;
      end else begin
        check("hold_err", 64'(rsp_err), 64'(held_err));
        check("hold_a", 64'(rsp_a), 64'(held_a));
        check("hold_b", 64'(rsp_b), 64'(held_b));
        check("hold_c", 64'(rsp_c), 64'(held_c));
      end
    end
  end

  task automatic present(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [3:0] d, input int rem);
    txn_a[r]  = a;
    txn_b[r]  = b;
    txn_op[r] = op;
    txn_d[r]  = d;
    remaining[r] = rem;
    op_a_bus[r*32 +: 32] = a;
    op_b_bus[r*32 +: 32] = b;
    opr_bus[r*2 +: 2]    = op;
    dly_bus[r*4 +: 4]    = d;
    req[r] = 1'b1;
  endtask

  task automatic rand_present(input int r, input int rem);
    logic [31:0] b;
    logic [3:0]  d;
    d = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    b = $urandom;
    if (d == 0) b[3:0] = 4'($urandom_range(0, 10));
    present(r, $urandom, b, 2'($urandom_range(0, 3)), d, rem);
  endtask

  // One clock: requesters react to the grant seen last cycle.
  task automatic step();
    @(posedge clk);
    #1;
    noise = 1'($urandom_range(0, 1));
    for (int r = 0; r < N; r++) begin
      if (last_gnt[r]) begin
        if (remaining[r] > 0) rand_present(r, remaining[r] - 1);
        else req[r] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 600 && !reached; i++) begin
      step();
      if (req == '0 && sb.size() == 0 && cyc > busy_until + 1) reached = 1'b1;
    end
    check("idle_reached", 64'(reached), 64'd1);
  endtask

  initial begin
    for (int r = 0; r < N; r++) remaining[r] = 0;
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_en", 64'(fab_en), 64'd0);
    check("rst_strobe", 64'(fab_strobe), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_res", {rsp_a, rsp_b | rsp_c}, 64'd0);
    check("rst_operands", {fab_a, fab_b}, 64'd0);
    check("rst_op_dly", 64'({fab_op, fab_dly}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    present(0, 32'd5, 32'd7, 2'd1, 4'd3, 0);       // fixed delay 3
    wait_idle();
    present(0, 32'h100, 32'h16, 2'd2, 4'd0, 0);    // done at WAIT 6, done also in ISSUE
    wait_idle();
    present(1, 32'h55, 32'h10, 2'd3, 4'd0, 0);     // never done: timeout
    wait_idle();
    present(1, 32'h77, 32'h08, 2'd0, 4'd0, 0);     // done in last allowed WAIT cycle
    wait_idle();
    present(0, 32'h99, 32'h09, 2'd1, 4'd0, 0);     // done one cycle too late
    wait_idle();
    present(0, 32'hffff_ffff, 32'h2, 2'd3, 4'd15, 0);  // maximum fixed delay
    wait_idle();
    present(0, 32'h1, 32'h2, 2'd0, 4'd1, 3);       // contention, held requests
    present(1, 32'h3, 32'h4, 2'd1, 4'd2, 3);
    wait_idle();
    present(0, 32'ha, 32'hb, 2'd2, 4'd2, 0);       // owner withdraws after grant
    present(1, 32'hc, 32'h5, 2'd3, 4'd0, 0);
    wait_idle();

    for (int i = 0; i < 2500; i++) begin
      step();
      for (int r = 0; r < N; r++)
        if (!req[r] && $urandom_range(0, 5) == 0) rand_present(r, $urandom_range(0, 2));
    end
    for (int r = 0; r < N; r++) remaining[r] = 0;
    wait_idle();

    // Reset while in WAIT.
    present(0, 32'h42, 32'h0, 2'd1, 4'd0, 0);
    for (int i = 0; i < 20 && !(fab_en && !fab_strobe); i++) step();
    check("reached_wait", 64'(fab_en && !fab_strobe), 64'd1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    req    = '0;
    #1;
    check("arst_en", 64'(fab_en), 64'd0);
    check("arst_strobe", 64'(fab_strobe), 64'd0);
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_res", {rsp_a | rsp_b, rsp_c}, 64'd0);
    sb.delete();
    ptr        = 0;
    busy_until = -1;
    issue_cyc  = -100;
    held_err   = 1'b0;
    held_a     = '0;
    held_b     = '0;
    held_c     = '0;
    for (int r = 0; r < N; r++) remaining[r] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    present(0, 32'h11, 32'h22, 2'd0, 4'd2, 0);
    present(1, 32'h33, 32'h44, 2'd1, 4'd3, 0);
    wait_idle();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
